// File: rtl/rfkit_pkg.sv
// Shared RF datapath types: the sample format used by the BPSK front end and fir_rrc.
package rfkit_pkg;

  localparam int SAMPLE_WIDTH = 12;
  localparam int SAMPLE_MAX   = 2047;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/bpsk_upsampler_mapper.sv
// Combinational BPSK symbol mapper: bit 0 -> +AMPLITUDE, bit 1 -> -AMPLITUDE.
module bpsk_mapper
  import rfkit_pkg::*;
#(
  parameter int AMPLITUDE = SAMPLE_MAX
) (
  input  logic    bit_in,
  output sample_t sample
);

  localparam sample_t POS = sample_t'(AMPLITUDE);
  localparam sample_t NEG = sample_t'(-AMPLITUDE);

  assign sample = bit_in ? NEG : POS;

endmodule

// File: rtl/bpsk_upsampler.sv
// BPSK upsampler: one-entry bit buffer, symbol mapping and zero-stuffing to
// SAMPLES_PER_SYMBOL samples per symbol, with starvation tracking.
module bpsk_upsampler
  import rfkit_pkg::*;
#(
  parameter int SAMPLES_PER_SYMBOL = 4,
  parameter int AMPLITUDE          = 2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output sample_t     out,
  output logic        symbol_strobe,
  output logic        underflow,
  output logic [15:0] underflow_count
);

  if (SAMPLES_PER_SYMBOL < 2 || SAMPLES_PER_SYMBOL > 16) begin : g_bad_sps
    $error("bpsk_upsampler: SAMPLES_PER_SYMBOL must be in 2..16");
  end
  if (AMPLITUDE < 1 || AMPLITUDE > SAMPLE_MAX) begin : g_bad_amp
    $error("bpsk_upsampler: AMPLITUDE must be in 1..2047");
  end

  localparam int             PW         = $clog2(SAMPLES_PER_SYMBOL);
  localparam logic [PW-1:0]  PHASE_LAST = PW'(SAMPLES_PER_SYMBOL - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic          hold_bit_q, hold_bit_d;
  logic          hold_valid_q, hold_valid_d;
  sample_t       out_q, out_d;
  logic          symbol_strobe_q, symbol_strobe_d;
  logic          underflow_q, underflow_d;
  logic [15:0]   underflow_count_q, underflow_count_d;

  logic    slot;
  logic    transfer;
  sample_t mapped;

  bpsk_mapper #(.AMPLITUDE(AMPLITUDE)) u_mapper (
    .bit_in (hold_bit_q),
    .sample (mapped)
  );

  // Ready in a slot even when full: the held bit is consumed on the same edge.
  assign slot      = enable && (phase_q == '0);
  assign bit_ready = !rst && (!hold_valid_q || slot);
  assign transfer  = bit_valid && bit_ready;

  always_comb begin
    phase_d           = phase_q;
    hold_bit_d        = hold_bit_q;
    hold_valid_d      = hold_valid_q;
    out_d             = '0;
    symbol_strobe_d   = 1'b0;
    underflow_d       = 1'b0;
    underflow_count_d = underflow_count_q;

    if (enable) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
      if (slot) begin
        if (hold_valid_q) begin
          out_d           = mapped;
          symbol_strobe_d = 1'b1;
          hold_valid_d    = 1'b0;
        end else begin
          underflow_d = 1'b1;
          if (underflow_count_q != 16'hFFFF) underflow_count_d = underflow_count_q + 16'd1;
        end
      end
    end else begin
      phase_d = '0;
    end

    // A refill overrides the consume above, so back-to-back symbols keep the entry full.
    if (transfer) begin
      hold_bit_d   = bit_in;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q           <= '0;
      hold_bit_q        <= 1'b0;
      hold_valid_q      <= 1'b0;
      out_q             <= '0;
      symbol_strobe_q   <= 1'b0;
      underflow_q       <= 1'b0;
      underflow_count_q <= '0;
    end else begin
      phase_q           <= phase_d;
      hold_bit_q        <= hold_bit_d;
      hold_valid_q      <= hold_valid_d;
      out_q             <= out_d;
      symbol_strobe_q   <= symbol_strobe_d;
      underflow_q       <= underflow_d;
      underflow_count_q <= underflow_count_d;
    end
  end

  assign out             = out_q;
  assign symbol_strobe   = symbol_strobe_q;
  assign underflow       = underflow_q;
  assign underflow_count = underflow_count_q;

endmodule

// File: tb/tb_bpsk_upsampler.sv
// Directed bench for bpsk_upsampler: row tables of per-cycle stimulus and
// expected outputs, plus hand sequences for async reset and counter saturation.
module tb_bpsk_upsampler;
  import rfkit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
  logic        enable2 = 1'b0, bit_in2 = 1'b0, bit_valid2 = 1'b0;
  logic        bit_ready, bit_ready2;
  sample_t     out, out2;
  logic        symbol_strobe, symbol_strobe2;
  logic        underflow, underflow2;
  logic [15:0] underflow_count, underflow_count2;

  always #5 clk = ~clk;

  bpsk_upsampler #(.SAMPLES_PER_SYMBOL(4), .AMPLITUDE(2047)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .out(out), .symbol_strobe(symbol_strobe),
    .underflow(underflow), .underflow_count(underflow_count)
  );

  bpsk_upsampler #(.SAMPLES_PER_SYMBOL(4), .AMPLITUDE(1000)) dut2 (
    .clk(clk), .rst(rst), .enable(enable2), .bit_in(bit_in2), .bit_valid(bit_valid2),
    .bit_ready(bit_ready2), .out(out2), .symbol_strobe(symbol_strobe2),
    .underflow(underflow2), .underflow_count(underflow_count2)
  );

  typedef struct {
    logic sel;
    logic en, v, b;
    logic rdy;
    int   out;
    logic strb, uf;
    int   cnt;
  } row_t;

  row_t rows[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void add(input logic sel, input logic en, input logic v, input logic b,
                              input logic rdy, input int o, input logic strb, input logic uf,
                              input int cnt);
    row_t r;
    r.sel = sel; r.en = en; r.v = v; r.b = b; r.rdy = rdy;
    r.out = o; r.strb = strb; r.uf = uf; r.cnt = cnt;
    rows.push_back(r);
  endfunction

  // Each row: drive inputs (1 ns after an edge), check bit_ready, clock, check outputs.
  task automatic run_rows(input string tag);
    foreach (rows[i]) begin
      if (rows[i].sel) begin
        enable2 = rows[i].en; bit_valid2 = rows[i].v; bit_in2 = rows[i].b;
      end else begin
        enable = rows[i].en; bit_valid = rows[i].v; bit_in = rows[i].b;
      end
      #1;
      check($sformatf("%s[%0d].bit_ready", tag, i),
            int'(rows[i].sel ? bit_ready2 : bit_ready), int'(rows[i].rdy));
      @(posedge clk); #1;
      check($sformatf("%s[%0d].out", tag, i), rows[i].sel ? int'(out2) : int'(out), rows[i].out);
      check($sformatf("%s[%0d].symbol_strobe", tag, i),
            int'(rows[i].sel ? symbol_strobe2 : symbol_strobe), int'(rows[i].strb));
      check($sformatf("%s[%0d].underflow", tag, i),
            int'(rows[i].sel ? underflow2 : underflow), int'(rows[i].uf));
      check($sformatf("%s[%0d].underflow_count", tag, i),
            int'(rows[i].sel ? underflow_count2 : underflow_count), rows[i].cnt);
    end
    rows.delete();
  endtask

  initial begin
    // Reset hold with hostile inputs.
    enable = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check("rst_hold.out", int'(out), 0);
      check("rst_hold.bit_ready", int'(bit_ready), 0);
      check("rst_hold.underflow_count", int'(underflow_count), 0);
    end
    enable = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    rst = 1'b0;

    // Single bit 0 then starvation: five empty slots.
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 2047, 1, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 1, 0, 0, 0, 0);
    for (int s = 1; s <= 5; s++) begin
      add(0, 1, 0, 0, 1, 0, 0, 1, s);
      for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 1, 0, 0, 0, s);
    end
    run_rows("starve");

    // Stream 0,1,1,0 with bit_valid held; first bit preloaded while idle.
    add(0, 0, 1, 0, 1, 0, 0, 0, 5);
    add(0, 1, 1, 1, 1, 2047, 1, 0, 5);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 1, 0, 0, 0, 0, 5);
    add(0, 1, 1, 1, 1, -2047, 1, 0, 5);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, 0, 0, 0, 0, 5);
    add(0, 1, 1, 0, 1, -2047, 1, 0, 5);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0, 0, 0, 0, 5);
    add(0, 1, 0, 0, 1, 2047, 1, 0, 5);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 1, 0, 0, 0, 5);
    run_rows("stream");

    // Load on an empty slot (underflows, bit waits), then enable gap at phase 2.
    add(0, 1, 1, 1, 1, 0, 0, 1, 6);
    add(0, 1, 0, 0, 0, 0, 0, 0, 6);
    for (int k = 0; k < 6; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 6);
    add(0, 1, 0, 0, 1, -2047, 1, 0, 6);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 1, 0, 0, 0, 6);
    run_rows("gap");

    // Emit a symbol while refilling, then async reset mid-cycle with a bit held.
    add(0, 0, 1, 0, 1, 0, 0, 0, 6);
    add(0, 1, 1, 1, 1, 2047, 1, 0, 6);
    run_rows("pre_rst");
    bit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst.out", int'(out), 0);
    check("async_rst.symbol_strobe", int'(symbol_strobe), 0);
    check("async_rst.bit_ready", int'(bit_ready), 0);
    check("async_rst.underflow_count", int'(underflow_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    add(0, 1, 0, 0, 1, 0, 0, 1, 1);
    run_rows("post_rst");

    // Saturation: preload the counter near full, then starve three more slots.
    force dut.underflow_count_q = 16'd65533;
    #1 release dut.underflow_count_q;
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 1, 0, 0, 0, 65533);
    add(0, 1, 0, 0, 1, 0, 0, 1, 65534);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 1, 0, 0, 0, 65534);
    add(0, 1, 0, 0, 1, 0, 0, 1, 65535);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 1, 0, 0, 0, 65535);
    add(0, 1, 0, 0, 1, 0, 0, 1, 65535);
    run_rows("sat");

    // AMPLITUDE=1000 instance: bits 1,0.
    add(1, 0, 1, 1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 1, -1000, 1, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 1000, 1, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 1, 0, 0, 0, 0);
    run_rows("amp1000");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
